// File: rtl/ex_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Radix-2 restoring, one quotient bit per cycle, with a stall output for the hazard unit.
module ex_div_unit #(
  parameter int XLEN = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] sr1,
  input  logic [XLEN-1:0] sr2,
  input  logic [4:0]      dr_in,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dr_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_op;
  logic              r_sa;
  logic              r_sb;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvs;
  logic [CNTW-1:0]   r_cnt;
  logic [4:0]        r_dr;

  logic              w_accept;
  logic              w_signed;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN-1:0]   w_r_sh;
  logic [XLEN:0]     w_t;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic              w_last;
  logic [XLEN-1:0]   w_fix_res;

  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? f_neg(v) : v;
  endfunction

  assign w_signed  = ~op[0];
  assign w_div0    = (sr2 == '0);
  assign w_ovf     = w_signed && (sr1 == {1'b1, {(XLEN-1){1'b0}}}) && (sr2 == '1);
  assign w_special = w_div0 | w_ovf;

  // Divide-by-zero wins over overflow; overflow quotient is sr1 itself (the most negative value).
  always_comb begin
    w_spec_res = '0;
    if (w_div0) w_spec_res = op[1] ? sr1 : '1;
    else        w_spec_res = op[1] ? '0 : sr1;
  end

  assign w_r_sh    = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_t       = {1'b0, w_r_sh} - {1'b0, r_dvs};
  assign w_rem_nxt = w_t[XLEN] ? w_r_sh : w_t[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_t[XLEN]};
  assign w_last    = (r_cnt == CNTW'(XLEN-1));

  // Quotient sign follows sa^sb, remainder sign follows the dividend.
  always_comb begin
    w_fix_res = '0;
    if (r_op[1]) w_fix_res = r_sa ? f_neg(w_rem_nxt) : w_rem_nxt;
    else         w_fix_res = (r_sa ^ r_sb) ? f_neg(w_quo_nxt) : w_quo_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    stall       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done        = (r_state == DONE);
        w_accept    = start & ~kill;
        w_state_nxt = w_accept ? (w_special ? DONE : CALC) : IDLE;
      end
      CALC: begin
        busy = 1'b1;
        if (kill)        w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
    stall = w_accept | busy;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_dr    <= '0;
      result  <= '0;
      dr_out  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= op;
        r_sa  <= w_signed & sr1[XLEN-1];
        r_sb  <= w_signed & sr2[XLEN-1];
        r_quo <= f_abs(sr1, w_signed);
        r_dvs <= f_abs(sr2, w_signed);
        r_rem <= '0;
        r_cnt <= '0;
        r_dr  <= dr_in;
        if (w_special) begin
          result <= w_spec_res;
          dr_out <= dr_in;
        end
      end else if (r_state == CALC && !kill) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt + CNTW'(1);
        if (w_last) begin
          result <= w_fix_res;
          dr_out <= r_dr;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: arithmetic reference model plus per-cycle scoreboard,
// directed scenarios and a randomized issue/kill phase.
module tb_ex_div_unit;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        start = 1'b0;
  logic        kill  = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] sr1   = '0;
  logic [31:0] sr2   = '0;
  logic [4:0]  dr_in = '0;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] result;
  logic [4:0]  dr_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit sb_en = 1'b0;

  always #5 clk = ~clk;

  ex_div_unit #(.XLEN(32), .CNTW(6)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .sr1    (sr1),
    .sr2    (sr2),
    .dr_in  (dr_in),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .result (result),
    .dr_out (dr_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M semantics straight from the arithmetic rules.
  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa_v;
    logic signed [31:0] sb_v;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      sa_v = a;
      sb_v = b;
      return o[1] ? 32'(sa_v % sb_v) : 32'(sa_v / sb_v);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Timing model: 32 busy cycles then a done pulse; special cases complete in one cycle.
  int          m_left;
  logic        m_done;
  logic [31:0] m_res;
  logic [31:0] m_pres;
  logic [4:0]  m_dr;
  logic [4:0]  m_pdr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_dr   <= '0;
    end else if (m_left > 0) begin
      m_done <= 1'b0;
      if (kill) begin
        m_left <= 0;
      end else if (m_left == 1) begin
        m_left <= 0;
        m_done <= 1'b1;
        m_res  <= m_pres;
        m_dr   <= m_pdr;
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (start && !kill) begin
        if (sr2 == 32'd0 || (!op[0] && sr1 == 32'h8000_0000 && sr2 == 32'hFFFF_FFFF)) begin
          m_done <= 1'b1;
          m_res  <= ref_op(op, sr1, sr2);
          m_dr   <= dr_in;
        end else begin
          m_left <= 32;
          m_pres <= ref_op(op, sr1, sr2);
          m_pdr  <= dr_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (sb_en) begin
      check("sb_busy",   32'(busy),  32'(m_left > 0));
      check("sb_done",   32'(done),  32'(m_done));
      check("sb_stall",  32'(stall), 32'((start && !kill && m_left == 0) || m_left > 0));
      check("sb_result", result,     m_res);
      check("sb_dr_out", 32'(dr_out), 32'(m_dr));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    op    = o;
    sr1   = a;
    sr2   = b;
    dr_in = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nd;

    check("ref_divu_100_7",  ref_op(2'b01, 32'd100, 32'd7), 32'd14);
    check("ref_rem_m7_2",    ref_op(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("ref_div_m7_2",    ref_op(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("ref_div_by0",     ref_op(2'b00, 32'd1234, 32'd0), 32'hFFFF_FFFF);
    check("ref_remu_by0",    ref_op(2'b11, 32'd1234, 32'd0), 32'd1234);
    check("ref_div_ovf",     ref_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("ref_rem_ovf",     ref_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    cycles(2);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", result,      32'd0);
    check("rst_dr_out", 32'(dr_out), 32'd0);
    sb_en = 1'b1;
    rstn  = 1'b1;
    cycles(1);

    issue(2'b01, 32'd100, 32'd7, 5'd5);
    wait_done(lat);
    check("divu_latency", 32'(lat), 32'd33);
    check("divu_result",  result, 32'd14);
    check("divu_dr_out",  32'(dr_out), 32'd5);
    cycles(2);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3);
    wait_done(lat);
    check("rem_neg_result", result, 32'hFFFF_FFFF);
    cycles(2);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4);
    wait_done(lat);
    check("div_neg_result", result, 32'hFFFF_FFFD);
    cycles(2);

    issue(2'b00, 32'd1234, 32'd0, 5'd7);
    check("div0_busy", 32'(busy), 32'd0);
    wait_done(lat);
    check("div0_latency", 32'(lat), 32'd1);
    check("div0_result",  result, 32'hFFFF_FFFF);
    cycles(2);
    issue(2'b11, 32'd1234, 32'd0, 5'd8);
    wait_done(lat);
    check("remu0_result", result, 32'd1234);
    cycles(2);

    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    check("ovf_busy", 32'(busy), 32'd0);
    wait_done(lat);
    check("ovf_latency", 32'(lat), 32'd1);
    check("ovf_div_result", result, 32'h8000_0000);
    cycles(2);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    wait_done(lat);
    check("ovf_rem_result", result, 32'd0);
    cycles(2);

    issue(2'b01, 32'd1000, 32'd3, 5'd10);
    cycles(9);
    kill = 1'b1;
    cycles(1);
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_done", 32'(done), 32'd0);
    cycles(1);
    issue(2'b01, 32'd9, 32'd3, 5'd11);
    wait_done(lat);
    check("post_kill_latency", 32'(lat), 32'd33);
    check("post_kill_result",  result, 32'd3);
    check("post_kill_dr_out",  32'(dr_out), 32'd11);
    cycles(2);

    issue(2'b01, 32'd77, 32'd7, 5'd12);
    wait_done(lat);
    check("b2b_first_result", result, 32'd11);
    issue(2'b01, 32'd50, 32'd5, 5'd13);
    wait_done(lat);
    check("b2b_latency", 32'(lat), 32'd33);
    check("b2b_result",  result, 32'd10);
    check("b2b_dr_out",  32'(dr_out), 32'd13);
    cycles(2);

    issue(2'b01, 32'hFFFF_FFFF, 32'd3, 5'd14);
    cycles(19);
    rstn = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_done",   32'(done), 32'd0);
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_dr_out", 32'(dr_out), 32'd0);
    cycles(1);
    rstn = 1'b1;
    nd = 0;
    repeat (40) begin
      cycles(1);
      if (done) nd++;
    end
    check("midrst_no_done", 32'(nd), 32'd0);

    repeat (6000) begin
      start = ($urandom_range(0, 2) == 0);
      kill  = ($urandom_range(0, 59) == 0);
      op    = 2'($urandom_range(0, 3));
      sr1   = pick();
      sr2   = pick();
      dr_in = 5'($urandom_range(0, 31));
      cycles(1);
    end
    start = 1'b0;
    kill  = 1'b0;
    cycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative RV32M divider in the EX stage, downstream of the ID/EX inter-segment register. It executes DIV, DIVU, REM and REMU using one radix-2 restoring iteration per cycle. While it works, it asserts a stall so the hazard logic can freeze IF/ID and ID/EX. The result is delivered with a destination-register tag to the EX/MEM result mux.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `CNTW`, default 6: iteration-counter width. It must be at least log2(XLEN)+1.

Ports:
- `clk`, input, 1: the single clock.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: issue request. Sampled only in `IDLE` or `DONE`.
- `kill`, input, 1: synchronous flush from the branch/exception logic.
- `op`, input, 2: operation code, equal to funct3[1:0]. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `sr1`, input, 32: dividend.
- `sr2`, input, 32: divisor.
- `dr_in`, input, 5: destination register index.
- `busy`, output, 1: high in `CALC`.
- `done`, output, 1: one-cycle pulse; `result` and `dr_out` are valid in that cycle.
- `stall`, output, 1: combinational. It equals (`start` & ~`kill` & state is `IDLE` or `DONE`) | `busy`.
- `result`, output, 32: quotient or remainder.
- `dr_out`, output, 5: destination register tag latched at `start`.

## Operation
- **States:** `IDLE`, `CALC`, `DONE`.
- **Reset:** state = `IDLE`, `busy` = 0, `done` = 0, `result` = 0, `dr_out` = 0, counter = 0.
- **Accepting a request:** in `IDLE` or `DONE`, `start`=1 and `kill`=0 latches `op` and `dr_in`, and the special-case flags below.
  - Signed ops (DIV, REM): latch |`sr1|` as dividend `A` and |`sr2|` as divisor `D`. Also latch `sa` = `sr1`[31] and `sb` = `sr2`[31].
  - Unsigned ops: `sa` = `sb` = 0.
- **Special cases** (go straight to `DONE` on the next edge):
  - Divisor = 0: quotient = 0xFFFFFFFF, remainder = `sr1`.
  - Signed overflow (`sr1`=0x80000000, `sr2`=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- **Normal case:** go to `CALC` with R = 0, Q = `A`, counter = 0.
- **CALC iteration:** each cycle, shift {R,Q} left by 1 bit and compute T = {1'b0,R_shifted} − {1'b0,`D`} (33-bit).
  - If T[32] = 0: R = T[31:0] and Q[0] = 1.
  - Otherwise keep R_shifted and set Q[0] = 0.
  - Counter increments. After the 32nd iteration, go to `DONE`.
- **Sign fix:** applied when `result` is registered on the `CALC`→`DONE` edge.
  - Quotient is negated if `sa`^`sb`.
  - Remainder is negated if `sa`.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- **DONE:** `done`=1 for exactly one cycle.
  - Next state is `CALC` or `DONE` if a new `start` is accepted (back-to-back issue), otherwise `IDLE`.
  - `result` and `dr_out` hold their value until the next completion.
- **kill:** has priority over `start` in every state.
  - In `CALC` it forces `IDLE` on the next edge, with no `done`.
  - In `DONE` the current `done` pulse still shows that cycle. The writeback is discarded by downstream flush logic.
  - Next state is `IDLE`.
- **start in CALC:** ignored. Upstream holds the instruction because `stall` is high.

## Timing
- **Normal latency:** `start` accepted in cycle 0 → `busy` high in cycles 1–32 → `done` in cycle 33.
- **Special-case latency:** `done` in cycle 1. `busy` never rises.
- **stall:** high from the accept cycle (cycle 0) through cycle 32. Low in the `done` cycle unless a new `start` is accepted in that cycle.
- **Reset mid-operation:** `rstn` low at any time forces all outputs to their reset values immediately (asynchronous). No `done` follows.

## Test plan
- **DIVU, normal latency:** `sr1`=100, `sr2`=7, `dr_in`=5 → `done` in cycle 33, `result`=14, `dr_out`=5. `stall` is high in cycles 0–32.
- **REM, negative dividend:** `sr1`=0xFFFFFFF9 (−7), `sr2`=2 → `result`=0xFFFFFFFF (−1). DIV with the same operands → 0xFFFFFFFD (−3).
- **Divide by zero:** DIV 1234/0 → `done` in cycle 1, `result`=0xFFFFFFFF, `busy` never 1. REMU 1234/0 → `result`=1234.
- **Signed overflow:** DIV 0x80000000/0xFFFFFFFF → `done` in cycle 1, `result`=0x80000000. REM with the same operands → 0.
- **Kill mid-operation:** `start` in cycle 0, `kill` in cycle 10 → `busy`=0 in cycle 11, no `done` ever. A new DIVU 9/3 issued in cycle 12 → `result`=3 in cycle 45.
- **Back-to-back and reset:**
  - `start` DIVU 50/5 asserted again in the `done` cycle of a prior op → second `done` 33 cycles later, `result`=10.
  - `rstn` pulsed low in cycle 20 of an op → `result`=0, `done`=0, state `IDLE`.
